// File: rtl/memory_sdp_pipe.sv
// memory_sdp_pipe: single-clock simple-dual-port RAM with per-byte write
// enables, selectable read-during-write behaviour, 1..3 cycle registered read
// latency with a valid strobe, and an optional post-reset clear sequencer.
module memory_sdp_pipe #(
  parameter int num_entries    = 8,
  parameter int data_bit_width = 32,
  parameter int byte_width     = 8,
  parameter int rd_latency     = 1,
  parameter int rdw_mode       = 0,
  parameter int init_on_reset  = 1,
  localparam int addr_bit_width = (num_entries > 1) ? $clog2(num_entries) : 1,
  localparam int num_bytes      = data_bit_width / byte_width
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [addr_bit_width-1:0] wr_addr,
  input  logic [data_bit_width-1:0] wr_data,
  input  logic [num_bytes-1:0]      wr_be,
  input  logic                      rd_en,
  input  logic [addr_bit_width-1:0] rd_addr,
  output logic [data_bit_width-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      init_busy
);

  // Depth as an (addr+1)-bit constant so range checks also work for
  // non-power-of-two depths.
  localparam logic [addr_bit_width:0]   LP_DEPTH = (addr_bit_width+1)'(num_entries);
  localparam logic [addr_bit_width-1:0] LP_LAST  = addr_bit_width'(num_entries - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] LP_RST_STATE = (init_on_reset != 0) ? ST_CLEAR : ST_IDLE;

  // Parameter sanity checks at elaboration.
  if ((data_bit_width % byte_width) != 0) begin : g_bad_width
    $error("memory_sdp_pipe: data_bit_width must be a multiple of byte_width");
  end
  if (rd_latency < 1 || rd_latency > 3) begin : g_bad_latency
    $error("memory_sdp_pipe: rd_latency must be 1..3");
  end
  if (num_entries < 2) begin : g_bad_depth
    $error("memory_sdp_pipe: num_entries must be >= 2");
  end

  logic [data_bit_width-1:0] r_mem [num_entries];

  logic [0:0]                r_state;
  logic [addr_bit_width-1:0] r_cnt;

  logic                      w_busy;
  logic                      w_wr_in_range;
  logic                      w_rd_in_range;
  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic [data_bit_width-1:0] w_mem_word;
  logic [data_bit_width-1:0] w_rd_word;

  logic [rd_latency:1]       r_vld_pipe;
  logic [data_bit_width-1:0] r_dat_pipe [1:rd_latency];

  assign w_busy        = (r_state == ST_CLEAR);
  assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);

  // Requests arriving while the clear sequencer owns the array are dropped.
  assign w_wr_acc = wr_en & ~w_busy & w_wr_in_range;
  assign w_rd_acc = rd_en & ~w_busy;

  assign init_busy = w_busy;

  // Clear sequencer: walks every entry once after reset, then idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LP_RST_STATE;
      r_cnt   <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_cnt == LP_LAST) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Array write port: clear has priority, otherwise byte-masked user write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_busy) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr_acc) begin
        for (int b = 0; b < num_bytes; b++) begin
          if (wr_be[b]) begin
            r_mem[wr_addr][b*byte_width +: byte_width] <= wr_data[b*byte_width +: byte_width];
          end
        end
      end
    end
  end

  assign w_mem_word = w_rd_in_range ? r_mem[rd_addr] : '0;

  // Read word with optional write-first bypass on a same-address collision.
  always_comb begin
    w_rd_word = w_mem_word;
    if ((rdw_mode != 0) && w_wr_acc && (wr_addr == rd_addr)) begin
      for (int b = 0; b < num_bytes; b++) begin
        if (wr_be[b]) begin
          w_rd_word[b*byte_width +: byte_width] = wr_data[b*byte_width +: byte_width];
        end
      end
    end
  end

  // Read pipeline: valid shifts every cycle, data stages load only on valid
  // so the output word holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int i = 1; i <= rd_latency; i++) begin
        r_dat_pipe[i] <= '0;
      end
    end else begin
      r_vld_pipe[1] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat_pipe[1] <= w_rd_word;
      end
      for (int i = 2; i <= rd_latency; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        if (r_vld_pipe[i-1]) begin
          r_dat_pipe[i] <= r_dat_pipe[i-1];
        end
      end
    end
  end

  assign rd_valid = r_vld_pipe[rd_latency];
  assign rd_data  = r_dat_pipe[rd_latency];

endmodule

// File: tb/tb_memory_sdp_pipe.sv
// Directed bench for memory_sdp_pipe. Three instances:
//   0: 8 entries, latency 1, read-first
//   1: 16 entries, latency 3, write-first
//   2: 6 entries, latency 2, read-first (odd depth)
module tb_memory_sdp_pipe;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        wr_en     [3];
  logic [3:0]  wr_addr   [3];
  logic [31:0] wr_data   [3];
  logic [3:0]  wr_be     [3];
  logic        rd_en     [3];
  logic [3:0]  rd_addr   [3];
  logic [31:0] rd_data   [3];
  logic        rd_valid  [3];
  logic        init_busy [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_sdp_pipe #(.num_entries(8), .data_bit_width(32), .byte_width(8),
    .rd_latency(1), .rdw_mode(0), .init_on_reset(1)) u_a (
    .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0][2:0]),
    .wr_data(wr_data[0]), .wr_be(wr_be[0]), .rd_en(rd_en[0]),
    .rd_addr(rd_addr[0][2:0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .init_busy(init_busy[0]));

  memory_sdp_pipe #(.num_entries(16), .data_bit_width(32), .byte_width(8),
    .rd_latency(3), .rdw_mode(1), .init_on_reset(1)) u_b (
    .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .wr_be(wr_be[1]), .rd_en(rd_en[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .init_busy(init_busy[1]));

  memory_sdp_pipe #(.num_entries(6), .data_bit_width(32), .byte_width(8),
    .rd_latency(2), .rdw_mode(0), .init_on_reset(1)) u_c (
    .clk(clk), .rst(rst[2]), .wr_en(wr_en[2]), .wr_addr(wr_addr[2][2:0]),
    .wr_data(wr_data[2]), .wr_be(wr_be[2]), .rd_en(rd_en[2]),
    .rd_addr(rd_addr[2][2:0]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
    .init_busy(init_busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int d);
    wr_en[d] = 1'b0;
    rd_en[d] = 1'b0;
  endtask

  task automatic wr(input int d, input int a, input logic [31:0] v, input logic [3:0] be);
    wr_en[d]   = 1'b1;
    wr_addr[d] = 4'(a);
    wr_data[d] = v;
    wr_be[d]   = be;
  endtask

  task automatic rd(input int d, input int a);
    rd_en[d]   = 1'b1;
    rd_addr[d] = 4'(a);
  endtask

  task automatic wrs(input int d, input int a, input logic [31:0] v, input logic [3:0] be);
    wr(d, a, v, be);
    step();
    nop(d);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; wr_en[d] = 1'b0; wr_addr[d] = '0; wr_data[d] = '0;
      wr_be[d] = '0; rd_en[d] = 1'b0; rd_addr[d] = '0;
    end
    step();
    step();

    // ---------------- instance 0: clear, byte enables, read-first RDW
    chk("a_rst_valid", 32'(rd_valid[0]), 32'd0);
    chk("a_rst_data", rd_data[0], 32'd0);
    chk("a_rst_busy", 32'(init_busy[0]), 32'd1);
    chk("b_rst_valid", 32'(rd_valid[1]), 32'd0);
    chk("b_rst_data", rd_data[1], 32'd0);
    rst[0] = 1'b0;
    rd(0, 2);  // held throughout the busy window: must be dropped
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("a_busy_%0d", i), 32'(init_busy[0]), (i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("a_busy_rd_%0d", i), 32'(rd_valid[0]), 32'd0);
    end
    nop(0);
    for (int a = 0; a < 8; a++) begin
      rd(0, a);
      step();
      chk($sformatf("a_clr_valid_%0d", a), 32'(rd_valid[0]), 32'd1);
      chk($sformatf("a_clr_data_%0d", a), rd_data[0], 32'd0);
    end
    nop(0);

    wrs(0, 3, 32'hAABBCCDD, 4'b1111);
    wrs(0, 3, 32'h11223344, 4'b0101);
    rd(0, 3); step(); nop(0);
    chk("a_be_valid", 32'(rd_valid[0]), 32'd1);
    chk("a_be_data", rd_data[0], 32'hAA22CC44);
    wrs(0, 3, 32'hDEADBEEF, 4'b0000);
    rd(0, 3); step(); nop(0);
    chk("a_be0_data", rd_data[0], 32'hAA22CC44);

    wrs(0, 5, 32'h12345678, 4'b1111);
    wr(0, 5, 32'hFFFFFFFF, 4'b0011); rd(0, 5); step(); nop(0);
    chk("a_rdw0_valid", 32'(rd_valid[0]), 32'd1);
    chk("a_rdw0_data", rd_data[0], 32'h12345678);
    rd(0, 5); step(); nop(0);
    chk("a_rdw0_after", rd_data[0], 32'h1234FFFF);
    step();
    chk("a_hold_valid", 32'(rd_valid[0]), 32'd0);
    chk("a_hold_data", rd_data[0], 32'h1234FFFF);
    wr(0, 1, 32'h55555555, 4'b1111); rd(0, 2); step(); nop(0);
    chk("a_diff_addr", rd_data[0], 32'd0);
    rd(0, 1); step(); nop(0);
    chk("a_diff_wr", rd_data[0], 32'h55555555);

    // ---------------- instance 1: reset mid-clear, latency 3, write-first RDW
    rst[1] = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("b_busy1_%0d", i), 32'(init_busy[1]), 32'd1);
    end
    rst[1] = 1'b1;
    step();
    chk("b_rerst_busy", 32'(init_busy[1]), 32'd1);
    rst[1] = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("b_busy2_%0d", i), 32'(init_busy[1]), (i < 16) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k <= 17; k++) begin
      if (k < 16) rd(1, k); else nop(1);
      step();
      chk($sformatf("b_clr_valid_%0d", k), 32'(rd_valid[1]), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk($sformatf("b_clr_data_%0d", k - 2), rd_data[1], 32'd0);
    end
    nop(1);
    for (int a = 0; a < 8; a++) wrs(1, a, 32'h01010101 * 32'(a + 1), 4'b1111);
    for (int k = 0; k <= 9; k++) begin
      if (k < 8) rd(1, k); else nop(1);
      step();
      chk($sformatf("b_lat_valid_%0d", k), 32'(rd_valid[1]), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk($sformatf("b_lat_data_%0d", k - 2), rd_data[1], 32'h01010101 * 32'(k - 1));
    end
    nop(1);
    step();
    chk("b_hold_valid", 32'(rd_valid[1]), 32'd0);
    chk("b_hold_data", rd_data[1], 32'h08080808);

    wrs(1, 5, 32'h12345678, 4'b1111);
    wr(1, 5, 32'hFFFFFFFF, 4'b0011); rd(1, 5); step(); nop(1);
    chk("b_rdw1_v1", 32'(rd_valid[1]), 32'd0);
    step();
    chk("b_rdw1_v2", 32'(rd_valid[1]), 32'd0);
    step();
    chk("b_rdw1_v3", 32'(rd_valid[1]), 32'd1);
    chk("b_rdw1_data", rd_data[1], 32'h1234FFFF);

    // ---------------- instance 2: odd depth, out-of-range accesses
    rst[2] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("c_busy_%0d", i), 32'(init_busy[2]), (i < 6) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 6; a++) wrs(2, a, 32'hC0 + 32'(a), 4'b1111);
    rd(2, 5); step(); nop(2);
    chk("c_rd5_v1", 32'(rd_valid[2]), 32'd0);
    step();
    chk("c_rd5_v2", 32'(rd_valid[2]), 32'd1);
    chk("c_rd5_data", rd_data[2], 32'hC5);
    wrs(2, 7, 32'hFFFFFFFF, 4'b1111);
    wrs(2, 6, 32'hFFFFFFFF, 4'b1111);
    rd(2, 7); step(); nop(2);
    chk("c_oor_v1", 32'(rd_valid[2]), 32'd0);
    step();
    chk("c_oor_v2", 32'(rd_valid[2]), 32'd1);
    chk("c_oor_data", rd_data[2], 32'd0);
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) rd(2, k); else nop(2);
      step();
      chk($sformatf("c_keep_valid_%0d", k), 32'(rd_valid[2]), (k >= 1) ? 32'd1 : 32'd0);
      if (k >= 1) chk($sformatf("c_keep_data_%0d", k - 1), rd_data[2], 32'hC0 + 32'(k - 1));
    end
    nop(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
